spi_target: RTL and testbench

SPI target (mode 0) with a small 16-bit register bank, oversampled entirely in the `ila_clk` domain. It gives a host processor register-level read/write access to board control and identification values over a 4-wire link. Each frame is 32 bits, MSB first: opcode[7:0], address[7:0], data[15:0].

---
 rtl/spi_target.sv | 155 +++++++++++++++
 tb/tb_spi_target.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/spi_target.sv
// SPI mode-0 target with a 16-entry, 16-bit register bank. All SPI pins are
// oversampled in the ila_clk domain; frames are opcode[7:0], addr[7:0], data[15:0].
module spi_target #(
  parameter logic [15:0] ID_VALUE  = 16'hC0DE,
  parameter logic [15:0] VER_VALUE = 16'h0100
) (
  input  logic        ila_clk,
  input  logic        rstn,
  input  logic        sclk_i,
  input  logic        csn_i,
  input  logic        mosi_i,
  output logic        miso_o,
  output logic [15:0] ctrl_o,
  output logic        wr_stb_o,
  output logic        frame_err_o
);

  typedef enum logic {IDLE, RECV} state_t;

  localparam logic [7:0] OP_WRITE = 8'h40;
  localparam logic [7:0] OP_READ  = 8'h41;
  localparam logic [5:0] CNT_ADDR = 6'd16;
  localparam logic [5:0] CNT_FULL = 6'd32;

  state_t      state, state_nxt;
  logic [1:0]  sclk_ff, csn_ff, mosi_ff;
  logic        sclk_prev, csn_prev;
  logic        sclk_rise, csn_rise, csn_fall;
  logic [5:0]  bit_cnt, cnt_nxt;
  logic [31:0] shift_in, shift_nxt;
  logic [15:0] shift_out;
  logic        reading;
  logic        bit_take, load_read, shift_rd, commit, abort;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic [15:0] rd_data;
  logic [15:0] rw_regs [2:15];

  // Two-flop synchronisers plus one history stage for edge detection.
  // Synced csn resets high so a reset never looks like a frame start.
  always_ff @(posedge ila_clk or negedge rstn) begin
    if (!rstn) begin
      sclk_ff   <= 2'b00;
      csn_ff    <= 2'b11;
      mosi_ff   <= 2'b00;
      sclk_prev <= 1'b0;
      csn_prev  <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling the pre-edge
      // value, which is what makes this a chain of stages and not one wire.
      sclk_ff   <= {sclk_ff[0], sclk_i};
      csn_ff    <= {csn_ff[0], csn_i};
      mosi_ff   <= {mosi_ff[0], mosi_i};
      sclk_prev <= sclk_ff[1];
      csn_prev  <= csn_ff[1];
    end
  end

  assign sclk_rise = sclk_ff[1] & ~sclk_prev;
  assign csn_rise  = csn_ff[1] & ~csn_prev;
  assign csn_fall  = ~csn_ff[1] & csn_prev;

  always_ff @(posedge ila_clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (csn_fall) state_nxt = RECV;
      RECV: if (csn_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A csn rise in the same cycle as an sclk rise drops the bit.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the block can leave a value held and infer a latch.
    cnt_nxt   = bit_cnt + 6'd1;
    shift_nxt = {shift_in[30:0], mosi_ff[1]};
    bit_take  = (state == RECV) && sclk_rise && !csn_rise && (bit_cnt < CNT_FULL);
    load_read = bit_take && (cnt_nxt == CNT_ADDR) && (shift_nxt[15:8] == OP_READ);
    shift_rd  = bit_take && reading && (cnt_nxt > CNT_ADDR);
    commit    = bit_take && (cnt_nxt == CNT_FULL) && (shift_nxt[31:24] == OP_WRITE);
    abort     = (state == RECV) && csn_rise && (bit_cnt != 6'd0) && (bit_cnt < CNT_FULL);
  end

  // Register read mux, addressed by the byte that completes at bit 16.
  always_comb begin
    rd_data = '0;
    if (shift_nxt[7:0] == 8'h00) rd_data = ID_VALUE;
    if (shift_nxt[7:0] == 8'h01) rd_data = VER_VALUE;
    for (int i = 2; i < 16; i++)
      if (shift_nxt[7:0] == 8'(i)) rd_data = rw_regs[i];
  end

  always_ff @(posedge ila_clk or negedge rstn) begin
    if (!rstn) begin
      bit_cnt     <= '0;
      shift_in    <= '0;
      shift_out   <= '0;
      reading     <= 1'b0;
      miso_o      <= 1'b0;
      wr_stb_o    <= 1'b0;
      frame_err_o <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
    end else begin
      wr_stb_o    <= commit;
      frame_err_o <= abort;
      if (commit) begin
        wr_addr <= shift_nxt[23:16];
        wr_data <= shift_nxt[15:0];
      end

      if (state == IDLE && csn_fall) begin
        bit_cnt  <= '0;
        shift_in <= '0;
        reading  <= 1'b0;
      end else if (bit_take) begin
        bit_cnt  <= cnt_nxt;
        shift_in <= shift_nxt;
      end

      if (state == IDLE || csn_rise) begin
        miso_o  <= 1'b0;
        reading <= 1'b0;
      end else if (load_read) begin
        shift_out <= rd_data;
        miso_o    <= rd_data[15];
        reading   <= 1'b1;
      end else if (shift_rd) begin
        shift_out <= {shift_out[14:0], 1'b0};
        miso_o    <= shift_out[14];
      end
    end
  end

  // The bank is written the cycle after wr_stb_o, so ctrl_o follows it by one.
  always_ff @(posedge ila_clk or negedge rstn) begin
    if (!rstn) begin
      // NOTE: the bank is only 14 flop words with defined reset values, so it
      // is reset like any other state rather than left to a RAM macro.
      for (int i = 2; i < 16; i++) rw_regs[i] <= '0;
    end else if (wr_stb_o) begin
      for (int i = 2; i < 16; i++)
        if (wr_addr == 8'(i)) rw_regs[i] <= wr_data;
    end
  end

  assign ctrl_o = rw_regs[2];

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: bit-bangs mode-0 frames with slow sclk and
// checks read data, commits, aborts and register side effects.
module tb_spi_target;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclk = 1'b0;
  logic        csn = 1'b1;
  logic        mosi = 1'b0;
  logic        miso;
  logic [15:0] ctrl;
  logic        wr_stb;
  logic        frame_err;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_cnt   = 0;
  int err_cnt  = 0;

  spi_target dut (
    .ila_clk     (clk),
    .rstn        (rst_n),
    .sclk_i      (sclk),
    .csn_i       (csn),
    .mosi_i      (mosi),
    .miso_o      (miso),
    .ctrl_o      (ctrl),
    .wr_stb_o    (wr_stb),
    .frame_err_o (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_stb)    wr_cnt++;
    if (frame_err) err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Host side: mosi set while sclk low, miso sampled just before each rise.
  // Bits past 32 are driven as ones so any late capture would be visible.
  task automatic send_frame(input logic [31:0] frame, input int nbits, input bit raise_cs,
                            output logic [15:0] rd, output logic early);
    rd    = '0;
    early = 1'b0;
    @(negedge clk);
    csn = 1'b0;
    wait_clk(8);
    for (int i = 0; i < nbits; i++) begin
      mosi = (i < 32) ? frame[31-i] : 1'b1;
      wait_clk(8);
      if (i < 16)      early = early | miso;
      else if (i < 32) rd = {rd[14:0], miso};
      sclk = 1'b1;
      wait_clk(8);
      sclk = 1'b0;
    end
    wait_clk(8);
    if (raise_cs) begin
      mosi = 1'b0;
      csn  = 1'b1;
      wait_clk(10);
    end
  endtask

  task automatic read_reg(input logic [7:0] addr, output logic [15:0] rd);
    logic early;
    send_frame({8'h41, addr, 16'h0000}, 32, 1'b1, rd, early);
  endtask

  initial begin
    logic [15:0] rd;
    logic        early;
    int          w0, e0;

    wait_clk(4);
    check("rst_miso", 32'(miso), 32'h0);
    check("rst_ctrl", 32'(ctrl), 32'h0);
    check("rst_wr_stb", 32'(wr_stb), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    rst_n = 1'b1;
    wait_clk(6);
    check("post_rst_miso", 32'(miso), 32'h0);
    check("post_rst_ctrl", 32'(ctrl), 32'h0);
    read_reg(8'h02, rd);
    check("post_rst_rd02", 32'(rd), 32'h0000);

    w0 = wr_cnt;
    send_frame(32'h4100_0000, 32, 1'b1, rd, early);
    check("rd_id", 32'(rd), 32'hC0DE);
    check("rd_id_early_miso", 32'(early), 32'h0);
    check("miso_idle", 32'(miso), 32'h0);
    read_reg(8'h01, rd);
    check("rd_ver", 32'(rd), 32'h0100);
    check("rd_no_wr_stb", 32'(wr_cnt - w0), 32'd0);

    w0 = wr_cnt;
    send_frame(32'h4002_A55A, 32, 1'b1, rd, early);
    check("wr02_stb", 32'(wr_cnt - w0), 32'd1);
    check("wr02_ctrl", 32'(ctrl), 32'hA55A);
    read_reg(8'h02, rd);
    check("rd02", 32'(rd), 32'hA55A);

    send_frame(32'h4001_FFFF, 32, 1'b1, rd, early);
    read_reg(8'h01, rd);
    check("rd01_readonly", 32'(rd), 32'h0100);
    send_frame(32'h4020_1234, 32, 1'b1, rd, early);
    read_reg(8'h20, rd);
    check("rd20_out_of_range", 32'(rd), 32'h0000);

    w0 = wr_cnt;
    e0 = err_cnt;
    send_frame(32'h4003_BEEF, 20, 1'b1, rd, early);
    check("abort_err", 32'(err_cnt - e0), 32'd1);
    check("abort_no_wr", 32'(wr_cnt - w0), 32'd0);
    read_reg(8'h03, rd);
    check("abort_rd03", 32'(rd), 32'h0000);

    e0 = err_cnt;
    send_frame(32'h0, 0, 1'b1, rd, early);
    check("idle_cs_no_err", 32'(err_cnt - e0), 32'd0);

    w0 = wr_cnt;
    send_frame(32'h7E02_0000, 32, 1'b1, rd, early);
    check("badop_miso", 32'({early, rd}), 32'h0);
    check("badop_ctrl", 32'(ctrl), 32'hA55A);
    check("badop_no_wr", 32'(wr_cnt - w0), 32'd0);

    w0 = wr_cnt;
    e0 = err_cnt;
    send_frame(32'h4004_1111, 40, 1'b1, rd, early);
    check("extra_bits_one_wr", 32'(wr_cnt - w0), 32'd1);
    check("extra_bits_no_err", 32'(err_cnt - e0), 32'd0);
    read_reg(8'h04, rd);
    check("rd04", 32'(rd), 32'h1111);
    check("ctrl_kept", 32'(ctrl), 32'hA55A);

    w0 = wr_cnt;
    e0 = err_cnt;
    send_frame(32'h4005_5555, 10, 1'b0, rd, early);
    rst_n = 1'b0;
    wait_clk(3);
    csn   = 1'b1;
    mosi  = 1'b0;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(10);
    check("midrst_no_err", 32'(err_cnt - e0), 32'd0);
    check("midrst_no_wr", 32'(wr_cnt - w0), 32'd0);
    check("midrst_ctrl", 32'(ctrl), 32'h0);
    read_reg(8'h04, rd);
    check("midrst_rd04", 32'(rd), 32'h0000);
    read_reg(8'h00, rd);
    check("midrst_rd_id", 32'(rd), 32'hC0DE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
